// File: rtl/tree_walker_pkg.sv
// Shared definitions for the decision-tree walker: node word layout, node kinds,
// walker FSM states.
package tree_walker_pkg;

  localparam int NODE_W = 64;

  localparam logic NODE_LEAF     = 1'b0;
  localparam logic NODE_DECISION = 1'b1;

  // Walker FSM states, also visible on the debug state output.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EVAL   = 3'd3,
    ST_RESULT = 3'd4
  } walker_state_t;

  // Node word, MSB first:
  // [63:32] value/threshold, [31:16] right child (local),
  // [15:8] feature index, [7:1] reserved, [0] node kind.
  typedef struct packed {
    logic [31:0] value;
    logic [15:0] right;
    logic [7:0]  f_index;
    logic [6:0]  rsvd;
    logic        kind;
  } tree_node_t;

endpackage

// File: rtl/tree_walker_if.sv
// Bus bundle between one tree walker lane and its surroundings.
//
// Handshakes (both valid/ready):
//  - Start: a walk is accepted on a clock edge where start && start_ready.
//    tree_base is sampled on that edge. start_ready is high only while idle.
//  - Result: res_valid stays high, and res_value/res_err/res_depth stay stable,
//    until an edge with res_valid && res_ready. After that edge res_valid is low.
//  - node_data is the registered RAM output for the node_addr of the previous cycle.
//  - feature is a combinational lookup of feat_index.
interface tree_walker_if #(
  parameter int NODE_AW = 10,
  parameter int FEAT_AW = 5,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 5
) ();
  import tree_walker_pkg::*;

  logic                start;
  logic                start_ready;
  logic [NODE_AW-1:0]  tree_base;
  logic [NODE_AW-1:0]  node_addr;
  logic [NODE_W-1:0]   node_data;
  logic [FEAT_AW-1:0]  feat_index;
  logic [DATA_W-1:0]   feature;
  logic                res_valid;
  logic                res_ready;
  logic [DATA_W-1:0]   res_value;
  logic                res_err;
  logic [DEPTH_W-1:0]  res_depth;
  walker_state_t       dbg_state;

  modport master (
    input  start, tree_base, node_data, feature, res_ready,
    output start_ready, node_addr, feat_index, res_valid,
           res_value, res_err, res_depth, dbg_state
  );

  modport slave (
    output start, tree_base, node_data, feature, res_ready,
    input  start_ready, node_addr, feat_index, res_valid,
           res_value, res_err, res_depth, dbg_state
  );

endinterface

// File: rtl/tree_walker.sv
// Decision-tree traversal engine: walks one tree rooted at a base address in a
// shared node memory, fetching features per decision node, and returns the leaf
// value with depth and error information.
module tree_walker
  import tree_walker_pkg::*;
#(
  parameter int N_NODE     = 1024,
  parameter int N_FEATURE  = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_DEPTH  = 16,
  parameter bit SIGNED_CMP = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  tree_walker_if.master bus
);

  localparam int NODE_AW = $clog2(N_NODE);
  localparam int FEAT_AW = $clog2(N_FEATURE);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  walker_state_t      r_state;
  walker_state_t      w_next_state;

  logic [NODE_AW-1:0] r_base;
  logic [NODE_AW-1:0] r_local;
  logic [NODE_AW-1:0] r_node_addr;
  logic [FEAT_AW-1:0] r_feat_index;
  tree_node_t         r_node;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_err;
  logic [DATA_W-1:0]  r_value;

  tree_node_t         w_node;
  logic               w_accept;
  logic               w_is_leaf;
  logic               w_depth_hit;
  logic               w_fidx_bad;
  logic               w_right_bad;
  logic               w_go_left;
  logic               w_abort;
  logic [NODE_AW-1:0] w_next_local;
  logic [NODE_AW-1:0] w_fetch_addr;
  logic               w_unused;

  // Reduce a sum of two in-range addresses back into [0, N_NODE).
  function automatic logic [NODE_AW-1:0] f_wrap(input logic [NODE_AW:0] sum);
    logic [NODE_AW:0] lim;
    lim = (NODE_AW+1)'(N_NODE);
    if (sum >= lim) return NODE_AW'(sum - lim);
    return sum[NODE_AW-1:0];
  endfunction

  // Branch-left test; signedness fixed at elaboration.
  function automatic logic f_less(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED_CMP) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  assign w_node   = bus.node_data;
  assign w_accept = (r_state == ST_IDLE) && bus.start;

  // Decision evaluation on the latched node and the live feature value.
  always_comb begin
    w_is_leaf    = (r_node.kind == NODE_LEAF);
    w_depth_hit  = (r_depth == DEPTH_W'(MAX_DEPTH));
    w_fidx_bad   = (32'(r_node.f_index) >= 32'(N_FEATURE));
    w_right_bad  = (32'(r_node.right) >= 32'(N_NODE));
    w_go_left    = f_less(bus.feature, DATA_W'(r_node.value));
    w_abort      = !w_is_leaf &&
                   (w_depth_hit || w_fidx_bad || (!w_go_left && w_right_bad));
    w_next_local = w_go_left ? f_wrap({1'b0, r_local} + 1'b1)
                             : NODE_AW'(r_node.right);
    w_fetch_addr = f_wrap({1'b0, r_base} + {1'b0, w_next_local});
  end

  // Reserved node bits carry no meaning for the walker.
  assign w_unused = ^r_node.rsvd;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start) w_next_state = ST_FETCH;
      ST_FETCH:  w_next_state = ST_DECODE;
      ST_DECODE: w_next_state = ST_EVAL;
      ST_EVAL:   w_next_state = (w_is_leaf || w_abort) ? ST_RESULT : ST_FETCH;
      ST_RESULT: if (bus.res_ready) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs and registered datapath onto the bus.
  always_comb begin
    bus.start_ready = (r_state == ST_IDLE);
    bus.res_valid   = (r_state == ST_RESULT);
    bus.node_addr   = r_node_addr;
    bus.feat_index  = r_feat_index;
    bus.res_value   = r_value;
    bus.res_err     = r_err;
    bus.res_depth   = r_depth;
    bus.dbg_state   = r_state;
  end

  // Walk datapath: base/local pointer, node latch, depth, error and result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base       <= '0;
      r_local      <= '0;
      r_node_addr  <= '0;
      r_feat_index <= '0;
      r_node       <= '0;
      r_depth      <= '0;
      r_err        <= 1'b0;
      r_value      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_base      <= bus.tree_base;
            r_local     <= '0;
            r_node_addr <= f_wrap({1'b0, bus.tree_base});
            r_depth     <= '0;
            r_err       <= 1'b0;
            r_value     <= '0;
          end
        end
        ST_DECODE: begin
          r_node       <= w_node;
          r_feat_index <= w_node.f_index[FEAT_AW-1:0];
        end
        ST_EVAL: begin
          if (w_is_leaf) begin
            r_value <= DATA_W'(r_node.value);
          end else if (w_depth_hit || w_fidx_bad) begin
            r_err   <= 1'b1;
            r_value <= '0;
          end else begin
            r_depth     <= r_depth + 1'b1;
            r_local     <= w_next_local;
            r_node_addr <= w_fetch_addr;
            if (!w_go_left && w_right_bad) begin
              r_err   <= 1'b1;
              r_value <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
